// File: rtl/inpkt_header_dispatch.sv
// Input packet front stage: parses the 8-byte header, forwards payload bytes with an end marker,
// and verifies the trailing inverted 32-bit byte-sum checksum.
module inpkt_header_dispatch #(
    parameter logic [7:0]  VERSION       = 8'd2,
    parameter logic [7:0]  PKT_TYPE_MASK = 8'h03,
    parameter int unsigned PKT_MAX_LEN   = 65536
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  din,
    input  logic        wr_en,
    output logic        full,
    output logic [7:0]  dout,
    output logic        dout_wr_en,
    output logic        dout_pkt_end,
    input  logic        dst_full,
    output logic [7:0]  pkt_type,
    output logic [15:0] pkt_id,
    output logic        pkt_done,
    output logic        err_ver,
    output logic        err_type,
    output logic        err_len,
    output logic        err_cksum
);

    typedef enum logic [1:0] {S_HEADER, S_DATA, S_CKSUM, S_ERROR} state_t;

    state_t      state, state_nx;
    logic [2:0]  hdr_cnt;
    logic [23:0] pkt_len;
    logic [23:0] data_cnt;
    logic [1:0]  ck_cnt;
    logic        ck_bad;
    logic [31:0] sum;

    logic        accept;
    logic        last_data;
    logic        ck_byte_bad;
    logic [23:0] len_full;
    logic [31:0] ck_expect;
    logic        type_bad;
    logic        len_bad;
    logic        set_ver, set_type, set_len, set_ck, ck_ok;

    assign full        = RESET || (state == S_ERROR) || ((state == S_DATA) && dst_full);
    assign accept      = wr_en && !full;
    assign len_full    = {din, pkt_len[15:0]};
    assign last_data   = (data_cnt == pkt_len - 24'd1);
    assign ck_expect   = ~sum;
    assign ck_byte_bad = (din != ck_expect[{ck_cnt, 3'b000} +: 8]);
    assign type_bad    = (din[7:3] != 5'd0) || !PKT_TYPE_MASK[din[2:0]];
    assign len_bad     = (len_full == 24'd0) || (32'(len_full) > PKT_MAX_LEN);

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_HEADER;
        else       state <= state_nx;
    end

    // Header checks fire on the accept cycle of the byte concerned; any error is terminal.
    always_comb begin
        state_nx = state;
        set_ver  = 1'b0;
        set_type = 1'b0;
        set_len  = 1'b0;
        set_ck   = 1'b0;
        ck_ok    = 1'b0;
        case (state)
            S_HEADER: begin
                if (accept) begin
                    case (hdr_cnt)
                        3'd0:    set_ver  = (din != VERSION);
                        3'd1:    set_type = type_bad;
                        3'd4:    set_len  = len_bad;
                        3'd7:    state_nx = S_DATA;
                        default: ;
                    endcase
                    if (set_ver || set_type || set_len) state_nx = S_ERROR;
                end
            end
            S_DATA: begin
                if (accept && last_data) state_nx = S_CKSUM;
            end
            S_CKSUM: begin
                if (accept && (ck_cnt == 2'd3)) begin
                    if (ck_bad || ck_byte_bad) begin
                        set_ck   = 1'b1;
                        state_nx = S_ERROR;
                    end else begin
                        ck_ok    = 1'b1;
                        state_nx = S_HEADER;
                    end
                end
            end
            S_ERROR: ;
            default: state_nx = S_HEADER;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hdr_cnt      <= 3'd0;
            pkt_len      <= 24'd0;
            data_cnt     <= 24'd0;
            ck_cnt       <= 2'd0;
            ck_bad       <= 1'b0;
            sum          <= 32'd0;
            dout         <= 8'd0;
            dout_wr_en   <= 1'b0;
            dout_pkt_end <= 1'b0;
            pkt_type     <= 8'd0;
            pkt_id       <= 16'd0;
            pkt_done     <= 1'b0;
            err_ver      <= 1'b0;
            err_type     <= 1'b0;
            err_len      <= 1'b0;
            err_cksum    <= 1'b0;
        end else begin
            dout_wr_en   <= 1'b0;
            dout_pkt_end <= 1'b0;
            pkt_done     <= ck_ok;
            err_ver      <= err_ver   | set_ver;
            err_type     <= err_type  | set_type;
            err_len      <= err_len   | set_len;
            err_cksum    <= err_cksum | set_ck;
            if (accept) begin
                case (state)
                    S_HEADER: begin
                        sum      <= sum + 32'(din);
                        hdr_cnt  <= hdr_cnt + 3'd1;
                        data_cnt <= 24'd0;
                        ck_cnt   <= 2'd0;
                        ck_bad   <= 1'b0;
                        case (hdr_cnt)
                            3'd1:    pkt_type        <= din;
                            3'd2:    pkt_len[7:0]    <= din;
                            3'd3:    pkt_len[15:8]   <= din;
                            3'd4:    pkt_len[23:16]  <= din;
                            3'd6:    pkt_id[7:0]     <= din;
                            3'd7:    pkt_id[15:8]    <= din;
                            default: ;
                        endcase
                    end
                    S_DATA: begin
                        sum          <= sum + 32'(din);
                        dout         <= din;
                        dout_wr_en   <= 1'b1;
                        dout_pkt_end <= last_data;
                        data_cnt     <= data_cnt + 24'd1;
                    end
                    S_CKSUM: begin
                        // The sum is cleared here so the next header starts from zero.
                        ck_cnt <= ck_cnt + 2'd1;
                        ck_bad <= ck_bad | ck_byte_bad;
                        if (ck_cnt == 2'd3) sum <= 32'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
